// File: rtl/wallace_mul_pipe.sv
// wallace_mul_pipe: pipelined A_W x B_W multiplier. Partial products are
// reduced by a Wallace (3:2 CSA) tree to sum/carry, then resolved by a CPA.
// Latency: STAGES cycles from accept to out_valid when the pipe is not stalled.
// Backpressure: global stall. Every stage holds while out_valid & !out_ready,
//   and in_ready drops in the same cycle. in_ready is also 0 while rst_n=0.
// Build option: define WALLACE_MUL_SIGNED_EN for a two's-complement product
//   (Baugh-Wooley). Leave it undefined for the unsigned-only build.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready/a/b/in_tag accept
//   side; out_valid/out_ready/z/out_tag deliver side; busy = any stage valid.
module wallace_mul_pipe #(
  parameter int A_W    = 26,
  parameter int B_W    = 24,
  parameter int STAGES = 2,
  parameter int TAG_W  = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [A_W-1:0]       a,
  input  logic [B_W-1:0]       b,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [A_W+B_W-1:0]   z,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int W   = A_W + B_W;
  // Enough 3:2 levels to bring 65 rows down to 2.
  localparam int LVL = 12;
`ifdef WALLACE_MUL_SIGNED_EN
  // One extra row holds the Baugh-Wooley correction constant
  // 2^(A_W-1) + 2^(B_W-1) + 2^(W-1), taken modulo 2^W.
  localparam int NR = B_W + 1;
  localparam logic [W-1:0] BW_K = (W'(1) << (A_W-1)) + (W'(1) << (B_W-1)) +
                                  (W'(1) << (W-1));
`else
  localparam int NR = B_W;
`endif

  logic [W-1:0]       w_sum;
  logic [W-1:0]       w_carry;
  logic               w_adv;
  logic               w_acc;
  logic [STAGES-1:0]  r_vld;
  logic [TAG_W-1:0]   r_tag [STAGES];
  logic [W-1:0]       r_z;

  // Partial-product generation and Wallace reduction. Each level takes rows
  // in groups of three and turns each group into a sum row and a carry row.
  // Rows left over (one or two) pass through to the next level unchanged.
  // The write index never overtakes the read index, so the reduction can
  // reuse one row array in place.
  always_comb begin : p_tree
    logic [W-1:0] rows [NR];
    logic [W-1:0] t0, t1, t2;
    int n, m, base;
    for (int j = 0; j < NR; j++) rows[j] = '0;
    for (int j = 0; j < B_W; j++) begin
      for (int i = 0; i < A_W; i++) begin
`ifdef WALLACE_MUL_SIGNED_EN
        // Cross terms that involve exactly one sign bit are negatively
        // weighted. They are inverted here, and BW_K absorbs the offset.
        rows[j][i+j] = (a[i] & b[j]) ^ ((i == A_W-1) != (j == B_W-1));
`else
        rows[j][i+j] = a[i] & b[j];
`endif
      end
    end
`ifdef WALLACE_MUL_SIGNED_EN
    rows[B_W] = BW_K;
`endif
    n = NR;
    for (int l = 0; l < LVL; l++) begin
      if (n > 2) begin
        m = 0;
        for (int g = 0; g < NR/3; g++) begin
          if (3*g + 2 < n) begin
            t0 = rows[3*g];
            t1 = rows[3*g+1];
            t2 = rows[3*g+2];
            rows[m]   = t0 ^ t1 ^ t2;
            // Carry-out beyond bit W-1 is dropped. The true product fits in
            // W bits, so this modulo arithmetic stays exact.
            rows[m+1] = ((t0 & t1) | (t0 & t2) | (t1 & t2)) << 1;
            m = m + 2;
          end
        end
        base = 3 * (n / 3);
        for (int k = 0; k < 2; k++) begin
          if (base + k < n) begin
            rows[m] = rows[base+k];
            m = m + 1;
          end
        end
        n = m;
      end
    end
    w_sum   = rows[0];
    w_carry = rows[1];
  end

  assign w_adv    = !r_vld[STAGES-1] | out_ready;
  assign in_ready = rst_n & w_adv;
  assign w_acc    = in_valid & in_ready;

  // Valid bits and tags move in lockstep. Bubbles travel like real entries.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_vld <= '0;
      for (int s = 0; s < STAGES; s++) r_tag[s] <= '0;
    end else if (w_adv) begin
      r_vld[0] <= w_acc;
      r_tag[0] <= in_tag;
      for (int s = 1; s < STAGES; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_tag[s] <= r_tag[s-1];
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_one
      always_ff @(posedge clk) begin
        if (!rst_n)     r_z <= '0;
        else if (w_adv) r_z <= w_sum + w_carry;
      end
    end else begin : g_multi
      // Stage 1 holds sum/carry. The extra stages delay that pair, and the
      // CPA feeds the final result register.
      logic [W-1:0] r_sum [STAGES-1];
      logic [W-1:0] r_car [STAGES-1];
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          for (int s = 0; s < STAGES-1; s++) begin
            r_sum[s] <= '0;
            r_car[s] <= '0;
          end
          r_z <= '0;
        end else if (w_adv) begin
          r_sum[0] <= w_sum;
          r_car[0] <= w_carry;
          for (int s = 1; s < STAGES-1; s++) begin
            r_sum[s] <= r_sum[s-1];
            r_car[s] <= r_car[s-1];
          end
          r_z <= r_sum[STAGES-2] + r_car[STAGES-2];
        end
      end
    end
  endgenerate

  // out_valid is gated by rst_n so that no delivery completes during reset.
  assign out_valid = r_vld[STAGES-1] & rst_n;
  assign z         = r_z;
  assign out_tag   = r_tag[STAGES-1];
  assign busy      = |r_vld;

endmodule

// File: tb/tb_wallace_mul_pipe.sv
module tb_wallace_mul_pipe;
  localparam int A_W    = 26;
  localparam int B_W    = 24;
  localparam int STAGES = 2;
  localparam int TAG_W  = 4;
  localparam int W      = A_W + B_W;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [A_W-1:0]   a;
  logic [B_W-1:0]   b;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [W-1:0]     z;
  logic [TAG_W-1:0] out_tag;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  wallace_mul_pipe #(.A_W(A_W), .B_W(B_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .out_tag(out_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; in_tag = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready got %b want 0", in_ready); end
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_tests++; if (z !== '0) begin n_fail++; $display("FAIL rst_z got %h want 0", z); end
    n_tests++; if (out_tag !== '0) begin n_fail++; $display("FAIL rst_tag got %h want 0", out_tag); end
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL post_rst_in_ready got %b want 1", in_ready); end
  endtask

  task automatic test_max();
    int lat;
    logic [W-1:0] zc;
    logic [TAG_W-1:0] tc;
    logic [W-1:0] exp_z;
`ifdef WALLACE_MUL_SIGNED_EN
    exp_z = 50'h1;
`else
    exp_z = 50'h3FFFFFB000001;
`endif
    lat = 0; zc = '0; tc = '0;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = 26'h3FFFFFF; b = 24'hFFFFFF; in_tag = 4'd5;
    for (int k = 1; k <= STAGES + 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid && lat == 0) begin lat = k; zc = z; tc = out_tag; end
    end
    n_tests++; if (lat != STAGES) begin n_fail++; $display("FAIL max_latency got %0d want %0d", lat, STAGES); end
    n_tests++; if (zc !== exp_z) begin n_fail++; $display("FAIL max_z got %h want %h", zc, exp_z); end
    n_tests++; if (tc !== 4'd5) begin n_fail++; $display("FAIL max_tag got %h want 5", tc); end
  endtask

  task automatic test_back_to_back();
    int cnt, first, last;
    cnt = 0; first = -1; last = -1;
    out_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_tests++; if (z !== W'(3*(cnt+1))) begin n_fail++; $display("FAIL b2b_z[%0d] got %0d want %0d", cnt, z, 3*(cnt+1)); end
        n_tests++; if (out_tag !== TAG_W'(cnt+1)) begin n_fail++; $display("FAIL b2b_tag[%0d] got %0d want %0d", cnt, out_tag, cnt+1); end
        if (first < 0) first = c;
        last = c;
        cnt++;
      end
      if (c < 8) begin
        n_tests++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_in_ready[%0d] got %b want 1", c, in_ready); end
        in_valid = 1'b1; a = A_W'(c+1); b = B_W'(3); in_tag = TAG_W'(c+1);
      end else begin
        in_valid = 1'b0;
      end
    end
    n_tests++; if (cnt != 8) begin n_fail++; $display("FAIL b2b_count got %0d want 8", cnt); end
    n_tests++; if (last - first != 7) begin n_fail++; $display("FAIL b2b_consecutive got span %0d want 7", last - first); end
  endtask

  task automatic test_stall();
    int pushed, got;
    bit acc;
    logic [W-1:0] sz;
    logic [TAG_W-1:0] st;
    pushed = 0; got = 0; acc = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < STAGES + 2; c++) begin
      @(negedge clk);
      if (acc) pushed++;
      if (pushed < 4) begin
        in_valid = 1'b1; a = A_W'(100*(pushed+1)); b = B_W'(3); in_tag = TAG_W'(9+pushed);
      end else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
    end
    n_tests++; if (pushed != STAGES) begin n_fail++; $display("FAIL stall_fill got %0d want %0d", pushed, STAGES); end
    n_tests++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL stall_out_valid got %b want 1", out_valid); end
    n_tests++; if (z !== W'(300)) begin n_fail++; $display("FAIL stall_head_z got %0d want 300", z); end
    sz = z; st = out_tag;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk); #1;
      n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL stall_in_ready[%0d] got %b want 0", c, in_ready); end
      n_tests++; if (z !== sz || out_tag !== st || out_valid !== 1'b1)
        begin n_fail++; $display("FAIL stall_hold[%0d] got z=%0d tag=%0d v=%b want z=%0d tag=%0d v=1", c, z, out_tag, out_valid, sz, st); end
    end
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (acc) pushed++;
      if (pushed < 4) begin
        in_valid = 1'b1; a = A_W'(100*(pushed+1)); b = B_W'(3); in_tag = TAG_W'(9+pushed);
      end else in_valid = 1'b0;
      #1;
      acc = in_valid && in_ready;
      if (out_valid) begin
        if (got < 4) begin
          n_tests++; if (z !== W'(300*(got+1)) || out_tag !== TAG_W'(9+got))
            begin n_fail++; $display("FAIL stall_drain[%0d] got z=%0d tag=%0d want z=%0d tag=%0d", got, z, out_tag, 300*(got+1), 9+got); end
        end else begin
          n_tests++; n_fail++; $display("FAIL stall_extra got z=%0d want no output", z);
        end
        got++;
      end
    end
    n_tests++; if (got != 4) begin n_fail++; $display("FAIL stall_count got %0d want 4", got); end
  endtask

  task automatic test_zero_one();
    int got;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_tests++;
        if (got == 0 && (z !== W'(0) || out_tag !== 4'd1)) begin n_fail++; $display("FAIL zero_z got z=%0d tag=%0d want z=0 tag=1", z, out_tag); end
        if (got == 1 && (z !== W'(1) || out_tag !== 4'd2)) begin n_fail++; $display("FAIL one_z got z=%0d tag=%0d want z=1 tag=2", z, out_tag); end
        if (got > 1) begin n_fail++; $display("FAIL zo_extra got z=%0d want no output", z); end
        got++;
      end
      if (c == 0) begin in_valid = 1'b1; a = '0; b = 24'hFFFFFF; in_tag = 4'd1; end
      else if (c == 1) begin in_valid = 1'b1; a = A_W'(1); b = B_W'(1); in_tag = 4'd2; end
      else in_valid = 1'b0;
    end
    n_tests++; if (got != 2) begin n_fail++; $display("FAIL zo_count got %0d want 2", got); end
  endtask

  task automatic test_reset_midflight();
    out_ready = 1'b0;
    @(negedge clk); in_valid = 1'b1; a = A_W'(5); b = B_W'(5); in_tag = 4'd3;
    @(negedge clk); in_valid = 1'b1; a = A_W'(6); b = B_W'(6); in_tag = 4'd4;
    @(negedge clk); in_valid = 1'b0;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy_before got %b want 1", busy); end
    rst_n = 1'b0; #1;
    n_tests++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready got %b want 0", in_ready); end
    @(negedge clk);
    n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_out_valid got %b want 0", out_valid); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got %b want 0", busy); end
    rst_n = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      n_tests++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL mid_stale[%0d] got z=%0d want no output", c, z); end
    end
  endtask

`ifdef WALLACE_MUL_SIGNED_EN
  task automatic test_signed();
    int got;
    got = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (out_valid) begin
        n_tests++;
        if (got == 0 && z !== 50'h3FFFFFFFFFFF1) begin n_fail++; $display("FAIL signed_m3x5 got %h want 3fffffffffff1", z); end
        if (got == 1 && z !== 50'h1) begin n_fail++; $display("FAIL signed_m1xm1 got %h want 1", z); end
        if (got > 1) begin n_fail++; $display("FAIL signed_extra got %h want no output", z); end
        got++;
      end
      if (c == 0) begin in_valid = 1'b1; a = 26'h3FFFFFD; b = 24'd5; in_tag = 4'd6; end
      else if (c == 1) begin in_valid = 1'b1; a = 26'h3FFFFFF; b = 24'hFFFFFF; in_tag = 4'd7; end
      else in_valid = 1'b0;
    end
    n_tests++; if (got != 2) begin n_fail++; $display("FAIL signed_count got %0d want 2", got); end
  endtask
`endif

  initial begin
    test_reset();
    test_max();
    test_back_to_back();
    test_stall();
    test_zero_one();
    test_reset_midflight();
`ifdef WALLACE_MUL_SIGNED_EN
    test_signed();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
